// File: rtl/wino_tile_accum.sv
// wino_tile_accum: sums PE 6x6 tiles over num_ch_i beats into a one-deep valid/ready buffer; define WINO_ACC_SAT_EN to saturate instead of wrap.
module wino_tile_accum #(
  parameter int ACC_W = 20
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic signed [11:0]      result_tile_i [0:5][0:5],
  input  logic                    result_valid_i,
  input  logic [7:0]              result_od_i,
  input  logic [8:0]              result_x_index_i,
  input  logic [8:0]              result_y_index_i,
  input  logic [7:0]              num_ch_i,
  output logic signed [ACC_W-1:0] acc_tile_o [0:5][0:5],
  output logic [7:0]              acc_od_o,
  output logic [8:0]              acc_x_index_o,
  output logic [8:0]              acc_y_index_o,
  output logic                    acc_valid_o,
  input  logic                    acc_ready_i,
  output logic                    busy_o,
  output logic                    overflow_o,
  output logic                    tag_err_o
);
  typedef enum logic {IDLE, ACCUM} state_t;
`ifdef WINO_ACC_SAT_EN
  localparam int XW = ACC_W + 1;
`else
  localparam int XW = ACC_W;
`endif
  state_t state;
  logic signed [ACC_W-1:0] acc [0:5][0:5];
  logic signed [ACC_W-1:0] sum [0:5][0:5];
  logic [7:0] cnt, tgt, tgt_new, od_q, od_c;
  logic [8:0] x_q, y_q, x_c, y_c;
  logic in_acc, done, load, tag_mis;
  always_comb begin
    in_acc  = state == ACCUM;
    tgt_new = num_ch_i == 8'd0 ? 8'd1 : num_ch_i;
    done    = result_valid_i && (in_acc ? {1'b0, cnt} + 9'd1 == {1'b0, tgt} : tgt_new == 8'd1);
    load    = done && (!acc_valid_o || acc_ready_i);
    tag_mis = in_acc && result_valid_i &&
              (result_od_i != od_q || result_x_index_i != x_q || result_y_index_i != y_q);
    od_c    = in_acc ? od_q : result_od_i;
    x_c     = in_acc ? x_q : result_x_index_i;
    y_c     = in_acc ? y_q : result_y_index_i;
  end
  for (genvar i = 0; i < 6; i++) begin : g_r
    for (genvar j = 0; j < 6; j++) begin : g_c
      logic signed [XW-1:0] wide;
      assign wide = (in_acc ? XW'(acc[i][j]) : XW'(0)) + XW'(result_tile_i[i][j]);
`ifdef WINO_ACC_SAT_EN
      // the extra top bit disagrees with the sign bit exactly when the add left range
      assign sum[i][j] = wide[XW-1] != wide[XW-2] ?
                         {wide[XW-1], {(ACC_W-1){~wide[XW-1]}}} : wide[ACC_W-1:0];
`else
      assign sum[i][j] = wide;
`endif
    end
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state         <= IDLE;
      cnt           <= '0;
      tgt           <= '0;
      od_q          <= '0;
      x_q           <= '0;
      y_q           <= '0;
      acc_od_o      <= '0;
      acc_x_index_o <= '0;
      acc_y_index_o <= '0;
      acc_valid_o   <= 1'b0;
      busy_o        <= 1'b0;
      overflow_o    <= 1'b0;
      tag_err_o     <= 1'b0;
      for (int i = 0; i < 6; i++)
        for (int j = 0; j < 6; j++) begin
          acc[i][j]        <= '0;
          acc_tile_o[i][j] <= '0;
        end
    end else begin
      if (result_valid_i) begin
        state  <= done ? IDLE : ACCUM;
        busy_o <= !done;
        cnt    <= done ? 8'd0 : cnt + 8'd1;
        for (int i = 0; i < 6; i++)
          for (int j = 0; j < 6; j++)
            acc[i][j] <= done ? '0 : sum[i][j];
        if (!in_acc) begin
          tgt  <= tgt_new;
          od_q <= result_od_i;
          x_q  <= result_x_index_i;
          y_q  <= result_y_index_i;
        end
      end
      if (load) begin
        acc_tile_o    <= sum;
        acc_od_o      <= od_c;
        acc_x_index_o <= x_c;
        acc_y_index_o <= y_c;
      end
      acc_valid_o <= load || (acc_valid_o && !acc_ready_i);
      overflow_o  <= overflow_o || (done && !load);
      tag_err_o   <= tag_err_o || tag_mis;
    end
  end
endmodule

// File: tb/tb_wino_tile_accum.sv
// tb_wino_tile_accum: directed scoreboard bench for wino_tile_accum (ACC_W=20 main DUT, ACC_W=12 DUT for range limits).
module tb_wino_tile_accum;
  logic clk = 0, reset = 0;
  logic signed [11:0] result_tile_i [0:5][0:5];
  logic result_valid_i = 0, v2 = 0, acc_ready_i = 0;
  logic [7:0] result_od_i = 0, num_ch_i = 0;
  logic [8:0] result_x_index_i = 0, result_y_index_i = 0;
  logic signed [19:0] acc_tile_o [0:5][0:5];
  logic [7:0] acc_od_o;
  logic [8:0] acc_x_index_o, acc_y_index_o;
  logic acc_valid_o, busy_o, overflow_o, tag_err_o;
  logic signed [11:0] t2 [0:5][0:5];
  logic [7:0] od2;
  logic [8:0] x2, y2;
  logic val2, busy2, ovf2, terr2;
  int n_chk = 0, n_fail = 0;
  typedef struct {int base; bit ramp; int od; int x; int y;} exp_t;
  exp_t q[$];

  always #5 clk = ~clk;

  wino_tile_accum #(.ACC_W(20)) dut (
    .clk(clk), .reset(reset), .result_tile_i(result_tile_i), .result_valid_i(result_valid_i),
    .result_od_i(result_od_i), .result_x_index_i(result_x_index_i), .result_y_index_i(result_y_index_i),
    .num_ch_i(num_ch_i), .acc_tile_o(acc_tile_o), .acc_od_o(acc_od_o), .acc_x_index_o(acc_x_index_o),
    .acc_y_index_o(acc_y_index_o), .acc_valid_o(acc_valid_o), .acc_ready_i(acc_ready_i),
    .busy_o(busy_o), .overflow_o(overflow_o), .tag_err_o(tag_err_o));

  wino_tile_accum #(.ACC_W(12)) dut12 (
    .clk(clk), .reset(reset), .result_tile_i(result_tile_i), .result_valid_i(v2),
    .result_od_i(result_od_i), .result_x_index_i(result_x_index_i), .result_y_index_i(result_y_index_i),
    .num_ch_i(num_ch_i), .acc_tile_o(t2), .acc_od_o(od2), .acc_x_index_o(x2),
    .acc_y_index_o(y2), .acc_valid_o(val2), .acc_ready_i(acc_ready_i),
    .busy_o(busy2), .overflow_o(ovf2), .tag_err_o(terr2));

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_tile(input int v, input bit ramp);
    for (int i = 0; i < 6; i++)
      for (int j = 0; j < 6; j++)
        result_tile_i[i][j] = ramp ? 12'(i * 6 + j - 18) : 12'(v);
  endtask

  task automatic beat(input int v, input bit ramp, input int nch, input int od, input int x, input int y);
    set_tile(v, ramp);
    num_ch_i = 8'(nch);
    result_od_i = 8'(od);
    result_x_index_i = 9'(x);
    result_y_index_i = 9'(y);
    result_valid_i = 1;
    tick();
    result_valid_i = 0;
  endtask

  task automatic do_reset();
    reset = 0;
    tick();
    reset = 1;
  endtask

  task automatic check_out(input string tag);
    exp_t e;
    chk({tag, "_pending"}, q.size() > 0, 1);
    if (q.size() == 0) return;
    e = q.pop_front();
    chk({tag, "_valid"}, acc_valid_o, 1);
    for (int i = 0; i < 6; i++)
      for (int j = 0; j < 6; j++)
        chk($sformatf("%s_tile[%0d][%0d]", tag, i, j), acc_tile_o[i][j], e.ramp ? i * 6 + j - 18 : e.base);
    chk({tag, "_od"}, acc_od_o, e.od);
    chk({tag, "_x"}, acc_x_index_o, e.x);
    chk({tag, "_y"}, acc_y_index_o, e.y);
  endtask

  initial begin
    set_tile(0, 0);
    tick();
    tick();
    chk("rst_valid", acc_valid_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_ovf", overflow_o, 0);
    chk("rst_tagerr", tag_err_o, 0);
    chk("rst_tile00", acc_tile_o[0][0], 0);
    chk("rst_tile55", acc_tile_o[5][5], 0);
    chk("rst_od", acc_od_o, 0);
    reset = 1;
    // three-channel group of fives
    q.push_back('{15, 0, 3, 10, 15});
    beat(5, 0, 3, 3, 10, 15);
    chk("g3_busy1", busy_o, 1);
    chk("g3_valid1", acc_valid_o, 0);
    beat(5, 0, 3, 3, 10, 15);
    chk("g3_valid2", acc_valid_o, 0);
    beat(5, 0, 3, 3, 10, 15);
    chk("g3_busy3", busy_o, 0);
    check_out("g3");
    acc_ready_i = 1;
    tick();
    chk("g3_drained", acc_valid_o, 0);
    // num_ch 0 acts as 1, ready held high
    q.push_back('{0, 1, 7, 20, 30});
    beat(0, 1, 0, 7, 20, 30);
    chk("n0_busy", busy_o, 0);
    check_out("n0");
    tick();
    chk("n0_pulse", acc_valid_o, 0);
    // full buffer drops the second completion
    acc_ready_i = 0;
    q.push_back('{1, 0, 1, 1, 1});
    beat(1, 0, 1, 1, 1, 1);
    chk("ovf_pre", overflow_o, 0);
    beat(2, 0, 1, 2, 2, 2);
    chk("ovf_set", overflow_o, 1);
    check_out("ovf_hold");
    acc_ready_i = 1;
    tick();
    chk("ovf_drained", acc_valid_o, 0);
    chk("ovf_sticky", overflow_o, 1);
    acc_ready_i = 0;
    do_reset();
    chk("rst2_ovf", overflow_o, 0);
    // back-to-back groups, drain coincides with second completion
    q.push_back('{2, 0, 1, 4, 4});
    beat(1, 0, 2, 1, 4, 4);
    beat(1, 0, 2, 1, 4, 4);
    chk("bb_busy_g1", busy_o, 0);
    check_out("bb_g1");
    q.push_back('{6, 0, 2, 5, 5});
    beat(3, 0, 2, 2, 5, 5);
    chk("bb_busy_g2", busy_o, 1);
    chk("bb_hold", acc_tile_o[2][3], 2);
    acc_ready_i = 1;
    beat(3, 0, 2, 2, 5, 5);
    chk("bb_ovf", overflow_o, 0);
    check_out("bb_g2");
    tick();
    chk("bb_drained", acc_valid_o, 0);
    acc_ready_i = 0;
    // tag mismatch mid-group is flagged but still summed
    q.push_back('{6, 0, 3, 8, 9});
    beat(1, 0, 3, 3, 8, 9);
    chk("tag_pre", tag_err_o, 0);
    beat(2, 0, 3, 4, 8, 9);
    chk("tag_set", tag_err_o, 1);
    beat(3, 0, 3, 3, 8, 9);
    check_out("tag");
    acc_ready_i = 1;
    tick();
    acc_ready_i = 0;
    // reset mid-group discards the partial sum
    beat(9, 0, 3, 5, 6, 7);
    chk("mid_busy", busy_o, 1);
    do_reset();
    chk("mid_busy_rst", busy_o, 0);
    chk("mid_tagerr_rst", tag_err_o, 0);
    q.push_back('{21, 0, 5, 6, 7});
    beat(7, 0, 3, 5, 6, 7);
    beat(7, 0, 3, 5, 6, 7);
    beat(7, 0, 3, 5, 6, 7);
    check_out("fresh");
    acc_ready_i = 1;
    tick();
    chk("fresh_drained", acc_valid_o, 0);
    // ACC_W=12 range limit
    set_tile(2047, 0);
    num_ch_i = 2;
    v2 = 1;
    tick();
    tick();
    v2 = 0;
    chk("w12_valid", val2, 1);
`ifdef WINO_ACC_SAT_EN
    chk("w12_sum00", t2[0][0], 2047);
    chk("w12_sum55", t2[5][5], 2047);
`else
    chk("w12_sum00", t2[0][0], -2);
    chk("w12_sum55", t2[5][5], -2);
`endif
    chk("main_idle", acc_valid_o, 0);
    chk("sb_empty", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
